pipeline_dump_unit: RTL and testbench

- Debug consumer sitting directly downstream of the Pipeline top, fed by its exported state buses (PC, register file, data memory).
- On a start request it freezes the pipeline through a clock-enable, then streams a fixed-format snapshot byte-by-byte to the UART transmitter over a start/busy/done handshake.
- When the stream completes it releases the pipeline.

---
 rtl/pipeline_dump_unit.sv | 79 +++++++
 tb/tb_pipeline_dump_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_dump_unit.sv
// pipeline_dump_unit: freezes the pipeline and streams a PC/regfile/dmem snapshot frame to a UART transmitter
// Ports: clk/reset (sync, active-high); start requests a dump; pc/registers/memories are the live state buses;
// tx_busy/tx_done come from the UART, tx_start/tx_data go to it; cpu_enable gates the pipeline;
// busy is high while a frame is in flight; done pulses once at frame end.
module pipeline_dump_unit #(
  parameter logic [7:0] HEADER        = 8'hA5,
  parameter int         PC_WIDTH      = 10,
  parameter int         NUM_REGS      = 32,
  parameter int         NUM_MEM_WORDS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          pc,
  input  logic [32*NUM_REGS-1:0]       registers,
  input  logic [32*NUM_MEM_WORDS-1:0]  memories,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic                         tx_start,
  output logic [7:0]                   tx_data,
  output logic                         cpu_enable,
  output logic                         busy,
  output logic                         done
);
  localparam int NUM_WORDS   = NUM_REGS + NUM_MEM_WORDS;
  localparam int FRAME_BYTES = 3 + 4*NUM_WORDS;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_idx, r_tx_data, w_off, w_byte;
  logic        r_tx_start, w_last, w_launch;
  logic [15:0] w_pc16;
  logic [31:0] w_words [NUM_WORDS];
  logic [31:0] w_word;
  genvar i;
  for (i = 0; i < NUM_REGS; i++) begin : g_regs
    assign w_words[i] = registers[32*i +: 32];
  end
  for (i = 0; i < NUM_MEM_WORDS; i++) begin : g_mems
    assign w_words[NUM_REGS+i] = memories[32*i +: 32];
  end
  assign w_pc16   = 16'(pc);
  // Payload bytes start at index 3; upper offset bits pick the word, low two bits the byte (MSB first).
  assign w_off    = r_idx - 8'd3;
  assign w_word   = w_words[w_off[7:2]];
  assign w_byte   = r_idx == 8'd0 ? HEADER :
                    r_idx == 8'd1 ? w_pc16[15:8] :
                    r_idx == 8'd2 ? w_pc16[7:0] :
                    w_word[{~w_off[1:0], 3'b000} +: 8];
  assign w_last   = r_idx == 8'(FRAME_BYTES-1);
  assign w_launch = r_state == SEND && !tx_busy;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? SEND : IDLE;
      SEND:    w_next = tx_busy ? SEND : WAIT;
      WAIT:    w_next = tx_done ? (w_last ? DONE : SEND) : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= 8'd0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_next;
      r_tx_start <= w_launch;
      r_tx_data  <= w_launch ? w_byte : r_tx_data;
      r_idx      <= r_state == IDLE ? 8'd0 :
                    (r_state == WAIT && tx_done && !w_last) ? r_idx + 8'd1 : r_idx;
    end
  end
  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign busy       = r_state == SEND || r_state == WAIT;
  assign cpu_enable = !busy;
  assign done       = r_state == DONE;
endmodule

// File: tb/tb_pipeline_dump_unit.sv
// tb_pipeline_dump_unit: randomized self-checking bench for pipeline_dump_unit with a UART responder model
module tb_pipeline_dump_unit;
  localparam int NR = 32, NM = 10, FB = 3 + 4*(NR+NM);
  logic clk = 0, reset = 1, start = 0, tx_busy = 0, extra_done = 0, uart_done = 0, uart_stray = 0;
  logic [9:0] pc = '0;
  logic [32*NR-1:0] registers = '0;
  logic [32*NM-1:0] memories = '0;
  logic tx_done, tx_start, cpu_enable, busy, done;
  logic [7:0] tx_data;
  int n_tests = 0, n_fail = 0, cnt = 0, n_done = 0, n_done_bad = 0;
  bit pend = 0, wd_ok = 0;
  logic [7:0] cap[$], exp_q[$];

  assign tx_done = uart_done | extra_done;

  pipeline_dump_unit dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .registers(registers), .memories(memories),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .cpu_enable(cpu_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // UART responder: captures every launched byte and answers with tx_done 10 cycles later;
  // optionally echoes a stray tx_done one cycle after the real one.
  always @(negedge clk) begin
    if (reset) begin
      cnt = 0;
      pend = 0;
      uart_done = 0;
    end else begin
      uart_done = 0;
      if (pend) begin
        uart_done = 1;
        pend = 0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          uart_done = 1;
          pend = uart_stray;
        end
      end
      if (tx_start) begin
        cap.push_back(tx_data);
        cnt = 10;
      end
      if (done) begin
        n_done++;
        if (!cpu_enable) n_done_bad++;
      end
    end
  end

  task automatic build_exp();
    logic [31:0] v;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back({6'b0, pc[9:8]});
    exp_q.push_back(pc[7:0]);
    for (int w = 0; w < NR + NM; w++) begin
      if (w < NR) v = registers[32*w +: 32];
      else v = memories[32*(w-NR) +: 32];
      for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
    end
  endtask

  task automatic rand_data();
    pc = 10'($urandom);
    for (int w = 0; w < NR; w++) registers[32*w +: 32] = $urandom;
    for (int w = 0; w < NM; w++) memories[32*w +: 32] = $urandom;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (n_done >= target) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    wd_ok = n_done >= target;
  endtask

  task automatic test_reset();
    int seen;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    n_tests++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_enable got %b exp 1", cpu_enable); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL idle_quiet got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_frame(input bit randomize_data);
    int errs, n;
    logic [7:0] fixed_head[11];
    fixed_head = '{8'hA5, 8'h02, 8'hA4, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01};
    if (randomize_data) rand_data();
    else begin
      pc = 10'h2A4;
      for (int w = 0; w < NR; w++) registers[32*w +: 32] = 32'h1000_0000 + w;
      for (int w = 0; w < NM; w++) memories[32*w +: 32] = 32'hC0DE_0000 + w;
    end
    build_exp();
    cap.delete();
    n_done = 0;
    n_done_bad = 0;
    pulse_start();
    n_tests++; if (busy !== 1'b1 || cpu_enable !== 1'b0) begin n_fail++; $display("FAIL frame_freeze got busy=%b cen=%b exp busy=1 cen=0", busy, cpu_enable); end
    wait_done(1, 4000);
    n_tests++; if (!wd_ok) begin n_fail++; $display("FAIL frame_timeout got done=%0d exp 1", n_done); end
    n_tests++; if (cap.size() != FB) begin n_fail++; $display("FAIL frame_len got %0d exp %0d", cap.size(), FB); end
    n = cap.size() < FB ? cap.size() : FB;
    errs = 0;
    for (int k = 0; k < n; k++) if (cap[k] !== exp_q[k]) begin
      errs++;
      if (errs <= 5) $display("FAIL frame_byte[%0d] got %h exp %h", k, cap[k], exp_q[k]);
    end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL frame_bytes got %0d wrong exp 0", errs); end
    if (!randomize_data && n == FB) begin
      errs = 0;
      for (int k = 0; k < 11; k++) if (cap[k] !== fixed_head[k]) errs++;
      n_tests++; if (errs != 0) begin n_fail++; $display("FAIL frame_head got %0d wrong exp 0", errs); end
      n_tests++; if ({cap[131], cap[132], cap[133], cap[134]} !== 32'hC0DE_0000) begin n_fail++; $display("FAIL frame_mem0 got %h%h%h%h exp C0DE0000", cap[131], cap[132], cap[133], cap[134]); end
      n_tests++; if (cap[FB-1] !== 8'h09) begin n_fail++; $display("FAIL frame_last got %h exp 09", cap[FB-1]); end
    end
    n_tests++; if (n_done != 1 || n_done_bad != 0) begin n_fail++; $display("FAIL frame_done got pulses=%0d no_cen=%0d exp 1 0", n_done, n_done_bad); end
    n_tests++; if (cpu_enable !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL frame_release got cen=%b busy=%b exp 1 0", cpu_enable, busy); end
  endtask

  task automatic test_busy_hold();
    int seen, errs;
    rand_data();
    build_exp();
    cap.delete();
    n_done = 0;
    tx_busy = 1;
    pulse_start();
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_start !== 1'b0) seen++;
    end
    n_tests++; if (seen != 0 || busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold got %0d starts busy=%b exp 0 1", seen, busy); end
    tx_busy = 0;
    @(negedge clk);
    n_tests++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL busy_release got start=%b data=%h exp 1 a5", tx_start, tx_data); end
    wait_done(1, 4000);
    errs = (cap.size() == FB) ? 0 : 1;
    if (errs == 0) for (int k = 0; k < FB; k++) if (cap[k] !== exp_q[k]) errs++;
    n_tests++; if (!wd_ok || errs != 0) begin n_fail++; $display("FAIL busy_frame got len=%0d errs=%0d exp len=%0d errs=0", cap.size(), errs, FB); end
  endtask

  task automatic test_stray();
    int errs;
    rand_data();
    build_exp();
    cap.delete();
    n_done = 0;
    uart_stray = 1;
    extra_done = 1;
    @(negedge clk);
    extra_done = 0;
    n_tests++; if (busy !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL stray_idle got busy=%b start=%b exp 0 0", busy, tx_start); end
    pulse_start();
    fork
      wait_done(1, 4000);
      begin
        for (int c = 0; c < 4000 && n_done == 0; c++) begin
          @(negedge clk);
          start = (busy && $urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
        end
        start = 0;
      end
    join
    uart_stray = 0;
    errs = 0;
    if (cap.size() == FB) for (int k = 0; k < FB; k++) if (cap[k] !== exp_q[k]) errs++;
    n_tests++; if (!wd_ok || cap.size() != FB || errs != 0) begin n_fail++; $display("FAIL stray_frame got len=%0d errs=%0d exp len=%0d errs=0", cap.size(), errs, FB); end
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || n_done != 1) begin n_fail++; $display("FAIL stray_no_retrigger got busy=%b done=%0d exp 0 1", busy, n_done); end
  endtask

  task automatic test_reset_mid();
    int errs;
    rand_data();
    build_exp();
    cap.delete();
    n_done = 0;
    pulse_start();
    for (int c = 0; c < 2000 && cap.size() < 51; c++) @(negedge clk);
    n_tests++; if (cap.size() != 51) begin n_fail++; $display("FAIL mid_reach got %0d bytes exp 51", cap.size()); end
    reset = 1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || cpu_enable !== 1'b1 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset got busy=%b cen=%b start=%b data=%h exp 0 1 0 00", busy, cpu_enable, tx_start, tx_data);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    cap.delete();
    n_done = 0;
    pulse_start();
    wait_done(1, 4000);
    errs = 0;
    if (cap.size() == FB) for (int k = 0; k < FB; k++) if (cap[k] !== exp_q[k]) errs++;
    n_tests++; if (cap.size() == 0 || cap[0] !== 8'hA5) begin n_fail++; $display("FAIL mid_restart got first=%h exp a5", cap.size() ? cap[0] : 8'hxx); end
    n_tests++; if (!wd_ok || cap.size() != FB || errs != 0) begin n_fail++; $display("FAIL mid_frame got len=%0d errs=%0d exp len=%0d errs=0", cap.size(), errs, FB); end
  endtask

  task automatic test_back_to_back();
    int errs, c;
    rand_data();
    build_exp();
    cap.delete();
    n_done = 0;
    start = 1;
    for (c = 0; c < 4000 && done !== 1'b1; c++) @(negedge clk);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first got done=%b exp 1", done); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || cpu_enable !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got busy=%b cen=%b done=%b exp 0 1 0", busy, cpu_enable, done); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b1 || cpu_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_restart got busy=%b cen=%b exp 1 0", busy, cpu_enable); end
    start = 0;
    wait_done(2, 4000);
    errs = 0;
    if (cap.size() == 2*FB) for (int k = 0; k < 2*FB; k++) if (cap[k] !== exp_q[k % FB]) errs++;
    n_tests++; if (!wd_ok || cap.size() != 2*FB || errs != 0) begin n_fail++; $display("FAIL b2b_frames got len=%0d errs=%0d exp len=%0d errs=0", cap.size(), errs, 2*FB); end
  endtask

  initial begin
    test_reset();
    test_frame(0);
    test_frame(1);
    test_busy_hold();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
